// File: rtl/ble_usb_pkg.sv
// Shared types and defaults for the BLE analyzer USB output path.
package ble_usb_pkg;

   localparam int unsigned USB_DATA_W      = 8;
   localparam int unsigned USB_ARB_TIMEOUT = 16;

   typedef logic [USB_DATA_W-1:0] usb_byte_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      GAP  = 2'd2
   } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after last_i, wrapping modulo NB_REQ.
module rr_arbiter #(
   parameter int unsigned NB_REQ = 4
) (
   input  logic [NB_REQ-1:0]         req_i,
   input  logic [$clog2(NB_REQ)-1:0] last_i,
   output logic [$clog2(NB_REQ)-1:0] winner_o,
   output logic                      any_o
);

   localparam int unsigned IDX_W = $clog2(NB_REQ);

   int idx;

   // Scan from farthest to nearest so the nearest requester after last_i overrides.
   always_comb begin
      winner_o = '0;
      any_o    = 1'b0;
      idx      = 0;
      for (int off = int'(NB_REQ); off > 0; off--) begin
         idx = (int'(last_i) + off) % int'(NB_REQ);
         if (req_i[IDX_W'(idx)]) begin
            winner_o = IDX_W'(idx);
            any_o    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/usb_frame_arbiter.sv
// Frame-atomic round-robin arbiter feeding the single USB byte output,
// with inter-frame gap and a stall watchdog that aborts dead frames.
module usb_frame_arbiter
   import ble_usb_pkg::*;
#(
   parameter int unsigned NB_REQ  = 4,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned TIMEOUT = USB_ARB_TIMEOUT
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [NB_REQ*DATA_W-1:0]  src_data_i,
   input  logic [NB_REQ-1:0]         src_valid_i,
   input  logic [NB_REQ-1:0]         src_last_i,
   output logic [NB_REQ-1:0]         src_ready_o,
   output logic [DATA_W-1:0]         data_o,
   output logic                      valid_o,
   output logic                      frame_o,
   output logic [$clog2(NB_REQ)-1:0] grant_o,
   output logic                      abort_o
);

   localparam int unsigned IDX_W = $clog2(NB_REQ);
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   arb_state_e        state, state_nxt;
   logic [CNT_W-1:0]  stall_cnt, stall_cnt_nxt;
   logic [IDX_W-1:0]  grant_nxt, rr_winner;
   logic              rr_any;
   logic [NB_REQ-1:0] ready_nxt;
   logic [DATA_W-1:0] data_nxt, sel_data;
   logic              valid_nxt, frame_nxt, abort_nxt;
   logic              sel_valid, sel_last, accept;

   rr_arbiter #(.NB_REQ(NB_REQ)) u_rr (
      .req_i    (src_valid_i),
      .last_i   (grant_o),
      .winner_o (rr_winner),
      .any_o    (rr_any)
   );

   // Byte lane of the granted source
   always_comb begin
      sel_data  = '0;
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      for (int unsigned i = 0; i < NB_REQ; i++) begin
         if (grant_o == IDX_W'(i)) begin
            sel_data  = src_data_i[i*DATA_W +: DATA_W];
            sel_valid = src_valid_i[i];
            sel_last  = src_last_i[i];
         end
      end
   end

   assign accept = (state == XFER) && sel_valid;

   // Next state, watchdog and registered output values
   always_comb begin
      state_nxt     = state;
      grant_nxt     = grant_o;
      stall_cnt_nxt = stall_cnt;
      data_nxt      = data_o;
      valid_nxt     = 1'b0;
      frame_nxt     = frame_o;
      abort_nxt     = 1'b0;
      ready_nxt     = '0;

      unique case (state)
         IDLE: begin
            frame_nxt = 1'b0;
            if (rr_any) begin
               state_nxt     = XFER;
               grant_nxt     = rr_winner;
               stall_cnt_nxt = '0;
            end
         end
         XFER: begin
            if (accept) begin
               data_nxt      = sel_data;
               valid_nxt     = 1'b1;
               frame_nxt     = 1'b1;
               stall_cnt_nxt = '0;
               if (sel_last) begin
                  state_nxt = GAP;
               end
            end else if (stall_cnt == CNT_W'(TIMEOUT - 1)) begin
               // This stall cycle is the TIMEOUT-th in a row: drop the frame.
               state_nxt     = GAP;
               abort_nxt     = 1'b1;
               frame_nxt     = 1'b0;
               stall_cnt_nxt = stall_cnt + CNT_W'(1);
            end else begin
               stall_cnt_nxt = stall_cnt + CNT_W'(1);
            end
         end
         GAP: begin
            state_nxt = IDLE;
            frame_nxt = 1'b0;
         end
         default: begin
            state_nxt = IDLE;
            frame_nxt = 1'b0;
         end
      endcase

      for (int unsigned i = 0; i < NB_REQ; i++) begin
         ready_nxt[i] = (state_nxt == XFER) && (grant_nxt == IDX_W'(i));
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= IDLE;
         grant_o     <= IDX_W'(NB_REQ - 1);
         stall_cnt   <= '0;
         src_ready_o <= '0;
         data_o      <= '0;
         valid_o     <= 1'b0;
         frame_o     <= 1'b0;
         abort_o     <= 1'b0;
      end else begin
         state       <= state_nxt;
         grant_o     <= grant_nxt;
         stall_cnt   <= stall_cnt_nxt;
         src_ready_o <= ready_nxt;
         data_o      <= data_nxt;
         valid_o     <= valid_nxt;
         frame_o     <= frame_nxt;
         abort_o     <= abort_nxt;
      end
   end

endmodule

// File: tb/tb_usb_frame_arbiter.sv
// Directed and randomized checks of usb_frame_arbiter against a frame-level reference model.
module tb_usb_frame_arbiter;

   localparam int unsigned NB  = 4;
   localparam int unsigned DW  = 8;
   localparam int unsigned TO  = 16;
   localparam int          NFR = 12;

   logic            clk = 1'b0;
   logic            rst;
   logic [NB*DW-1:0] src_data;
   logic [NB-1:0]   src_valid, src_last, src_ready;
   logic [DW-1:0]   data;
   logic            valid, frame, abort;
   logic [1:0]      grant;

   int n_tests = 0;
   int n_fail  = 0;

   // Randomized-phase reference model state
   logic [7:0]  fr_byte [NFR][4];
   int          fr_len  [NFR];
   int          srcq    [NB][$];
   int          tmpq    [NB][$];
   int          exp_fid [$];
   logic [7:0]  cur_q   [$];
   int          pos [NB];
   int          stall_left [NB];
   logic [NB-1:0] xfer;
   int          done_in, done_out, low_cnt, cyc, last, w, idx, fid;
   logic        prev_frame;

   usb_frame_arbiter #(.NB_REQ(NB), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .src_data_i  (src_data),
      .src_valid_i (src_valid),
      .src_last_i  (src_last),
      .src_ready_o (src_ready),
      .data_o      (data),
      .valid_o     (valid),
      .frame_o     (frame),
      .grant_o     (grant),
      .abort_o     (abort)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic out(input string tag, input logic [7:0] d, input logic v, input logic f,
                      input logic a, input logic [3:0] r, input logic [1:0] g);
      if (v) chk({tag, ".data"}, 32'(data), 32'(d));
      chk({tag, ".valid"}, 32'(valid), 32'(v));
      chk({tag, ".frame"}, 32'(frame), 32'(f));
      chk({tag, ".abort"}, 32'(abort), 32'(a));
      chk({tag, ".ready"}, 32'(src_ready), 32'(r));
      chk({tag, ".grant"}, 32'(grant), 32'(g));
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic drive(input int s, input logic v, input logic [7:0] d, input logic l);
      src_valid[s]          = v;
      src_data[s*DW +: DW]  = d;
      src_last[s]           = l;
   endtask

   initial begin
      rst = 1'b1; src_data = '0; src_valid = '0; src_last = '0;
      step(); step();
      chk("reset.data", 32'(data), 32'h0);
      out("reset", 8'h00, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd3);
      rst = 1'b0;

      // Three-byte frame from source 2
      drive(2, 1'b1, 8'hA1, 1'b0); step();
      out("t1.grant", 8'h00, 1'b0, 1'b0, 1'b0, 4'b0100, 2'd2);
      step();
      out("t1.b1", 8'hA1, 1'b1, 1'b1, 1'b0, 4'b0100, 2'd2);
      drive(2, 1'b1, 8'hA2, 1'b0); step();
      out("t1.b2", 8'hA2, 1'b1, 1'b1, 1'b0, 4'b0100, 2'd2);
      drive(2, 1'b1, 8'hA3, 1'b1); step();
      out("t1.b3", 8'hA3, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd2);
      drive(2, 1'b0, 8'h00, 1'b0); step();
      out("t1.end", 8'h00, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd2);

      // Source 1 stalls 5 cycles mid-frame: no abort
      drive(1, 1'b1, 8'hB1, 1'b0); step();
      out("t3.grant", 8'h00, 1'b0, 1'b0, 1'b0, 4'b0010, 2'd1);
      step();
      out("t3.b1", 8'hB1, 1'b1, 1'b1, 1'b0, 4'b0010, 2'd1);
      drive(1, 1'b0, 8'h00, 1'b0);
      repeat (5) begin
         step();
         out("t3.stall", 8'h00, 1'b0, 1'b1, 1'b0, 4'b0010, 2'd1);
      end
      drive(1, 1'b1, 8'hB2, 1'b0); step();
      out("t3.b2", 8'hB2, 1'b1, 1'b1, 1'b0, 4'b0010, 2'd1);
      drive(1, 1'b1, 8'hB3, 1'b1); step();
      out("t3.b3", 8'hB3, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd1);
      drive(1, 1'b0, 8'h00, 1'b0); step();
      out("t3.end", 8'h00, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd1);

      // Source 1 stalls TIMEOUT cycles: abort, then source 2 wins
      drive(1, 1'b1, 8'hC1, 1'b0); step();
      out("t4.grant", 8'h00, 1'b0, 1'b0, 1'b0, 4'b0010, 2'd1);
      step();
      out("t4.b1", 8'hC1, 1'b1, 1'b1, 1'b0, 4'b0010, 2'd1);
      drive(1, 1'b0, 8'h00, 1'b0);
      drive(2, 1'b1, 8'hD1, 1'b1);
      repeat (TO - 1) begin
         step();
         out("t4.stall", 8'h00, 1'b0, 1'b1, 1'b0, 4'b0010, 2'd1);
      end
      step();
      out("t4.abort", 8'h00, 1'b0, 1'b0, 1'b1, 4'b0000, 2'd1);
      step();
      out("t4.idle", 8'h00, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd1);
      step();
      out("t4.regrant", 8'h00, 1'b0, 1'b0, 1'b0, 4'b0100, 2'd2);
      step();
      out("t4.d1", 8'hD1, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd2);
      drive(2, 1'b0, 8'h00, 1'b0); step();
      out("t4.end", 8'h00, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd2);

      // Single-byte frame from source 0, then earliest next grant
      drive(0, 1'b1, 8'h5C, 1'b1); step();
      out("t6.grant", 8'h00, 1'b0, 1'b0, 1'b0, 4'b0001, 2'd0);
      step();
      out("t6.byte", 8'h5C, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd0);
      drive(0, 1'b0, 8'h00, 1'b0); step();
      out("t6.gap", 8'h00, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0);
      drive(3, 1'b1, 8'h3C, 1'b1); step();
      out("t6.next", 8'h00, 1'b0, 1'b0, 1'b0, 4'b1000, 2'd3);
      step();
      out("t6.nbyte", 8'h3C, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd3);
      drive(3, 1'b0, 8'h00, 1'b0); step();
      out("t6.end", 8'h00, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd3);

      // Reset during byte 2 of a 4-byte frame
      drive(1, 1'b1, 8'hE1, 1'b0); step();
      out("t5.grant", 8'h00, 1'b0, 1'b0, 1'b0, 4'b0010, 2'd1);
      step();
      out("t5.b1", 8'hE1, 1'b1, 1'b1, 1'b0, 4'b0010, 2'd1);
      drive(1, 1'b1, 8'hE2, 1'b0); rst = 1'b1; step();
      chk("t5.rst.data", 32'(data), 32'h0);
      out("t5.rst", 8'h00, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd3);
      rst = 1'b0;
      drive(1, 1'b0, 8'h00, 1'b0);
      drive(3, 1'b1, 8'hF1, 1'b1); step();
      out("t5.grant3", 8'h00, 1'b0, 1'b0, 1'b0, 4'b1000, 2'd3);
      step();
      out("t5.f1", 8'hF1, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd3);
      drive(3, 1'b0, 8'h00, 1'b0); step();
      out("t5.end", 8'h00, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd3);

      // Randomized traffic: every source holds queued frames, bytes stall < TIMEOUT
      for (int f = 0; f < NFR; f++) begin
         fr_len[f] = int'($urandom_range(1, 4));
         for (int b = 0; b < 4; b++) fr_byte[f][b] = 8'($urandom);
         srcq[f % NB].push_back(f);
      end
      for (int s = 0; s < NB; s++) tmpq[s] = srcq[s];
      last = 3;
      repeat (NFR) begin
         w = -1;
         for (int off = 1; off <= NB; off++) begin
            idx = (last + off) % NB;
            if (w < 0 && tmpq[idx].size() > 0) w = idx;
         end
         exp_fid.push_back(tmpq[w].pop_front());
         last = w;
      end

      for (int s = 0; s < NB; s++) begin pos[s] = 0; stall_left[s] = 0; end
      xfer = '0; done_in = 0; done_out = 0; low_cnt = 10; cyc = 0; prev_frame = frame;
      while (done_out < NFR && cyc < 3000) begin
         step(); cyc++;
         chk("rnd.abort", 32'(abort), 32'h0);
         chk("rnd.ready_onehot", 32'($countones(src_ready) <= 1), 32'h1);
         if (src_ready != '0 && done_in < NFR)
            chk("rnd.ready_src", 32'(src_ready), 32'(1) << (exp_fid[done_in] % NB));
         if (valid && !frame) chk("rnd.valid_in_frame", 32'(frame), 32'h1);
         if (frame && !prev_frame) begin
            chk("rnd.gap", 32'(low_cnt >= 2), 32'h1);
            chk("rnd.grant", 32'(grant), 32'(exp_fid[done_out] % NB));
            cur_q.delete();
         end
         if (frame && valid) cur_q.push_back(data);
         if (!frame && prev_frame) begin
            fid = exp_fid[done_out];
            chk("rnd.len", 32'(cur_q.size()), 32'(fr_len[fid]));
            for (int i = 0; i < fr_len[fid]; i++)
               chk("rnd.byte", (i < cur_q.size()) ? 32'(cur_q[i]) : 32'hxx, 32'(fr_byte[fid][i]));
            done_out++;
         end
         low_cnt    = frame ? 0 : low_cnt + 1;
         prev_frame = frame;

         for (int s = 0; s < NB; s++) begin
            if (xfer[s]) begin
               if (pos[s] == fr_len[srcq[s][0]] - 1) begin
                  void'(srcq[s].pop_front());
                  pos[s] = 0;
                  done_in++;
               end else begin
                  pos[s]++;
                  if ($urandom_range(0, 3) == 0) stall_left[s] = int'($urandom_range(1, 5));
               end
            end
         end
         for (int s = 0; s < NB; s++) begin
            if (srcq[s].size() == 0) begin
               drive(s, 1'b0, 8'h00, 1'b0);
            end else if (stall_left[s] > 0) begin
               drive(s, 1'b0, 8'h00, 1'b0);
               stall_left[s]--;
            end else begin
               drive(s, 1'b1, fr_byte[srcq[s][0]][pos[s]], pos[s] == fr_len[srcq[s][0]] - 1);
            end
         end
         xfer = src_valid & src_ready;
      end
      chk("rnd.done", 32'(done_out), 32'(NFR));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
